// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port Data_Memory between two requesters, one transaction
// in flight at a time. Port 0 has fixed priority; port 1 wins once it has waited STARVE_LIMIT cycles.
module dmem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int RD_LATENCY   = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT      = 3'(RD_LATENCY);
  localparam logic [3:0] SLIM     = 4'(STARVE_LIMIT);
  localparam bit         LAT_ZERO = (RD_LATENCY == 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_lat_cnt, w_lat_nxt;
  logic [3:0]        r_starve_cnt, w_starve_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_wdata_nxt;
  logic              r_m0_gnt, r_m1_gnt, r_m0_rvalid, r_m1_rvalid;
  logic              r_mem_write, r_mem_read;
  logic              w_win, w_issue_nxt, w_rvalid_nxt;

  // Port 1 wins when alone, or when it has waited long enough to override port 0
  assign w_win = m1_req & (~m0_req | (r_starve_cnt >= SLIM));

  // Next-state logic; the mem_addr/mem_wdata registers double as the request latch
  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat_cnt;
    w_owner_nxt = r_owner;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_issue_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_req || m1_req) begin
          w_state_nxt = ISSUE;
          w_issue_nxt = 1'b1;
          w_owner_nxt = w_win;
          w_we_nxt    = w_win ? m1_we    : m0_we;
          w_addr_nxt  = w_win ? m1_addr  : m0_addr;
          w_wdata_nxt = w_win ? m1_wdata : m0_wdata;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (r_we || LAT_ZERO) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_RD;
          w_lat_nxt   = LAT;
        end
      end
      WAIT_RD: begin
        if (r_lat_cnt <= 3'd1) begin
          w_state_nxt = IDLE;
        end else begin
          w_lat_nxt = r_lat_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // rvalid is registered one cycle ahead so it lines up with ISSUE (latency 0) or lat_cnt==1
  always_comb begin
    if (w_issue_nxt && !w_we_nxt && LAT_ZERO) begin
      w_rvalid_nxt = 1'b1;
    end else if ((w_state_nxt == WAIT_RD) && (w_lat_nxt == 3'd1)) begin
      w_rvalid_nxt = 1'b1;
    end else begin
      w_rvalid_nxt = 1'b0;
    end
  end

  // Starvation counter: counts port-1 wait cycles, saturates, clears on its grant
  always_comb begin
    if (r_m1_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (m1_req && (r_starve_cnt < SLIM)) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end else begin
      w_starve_nxt = r_starve_cnt;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_lat_cnt    <= 3'd0;
      r_starve_cnt <= 4'd0;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_m0_gnt     <= 1'b0;
      r_m1_gnt     <= 1'b0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lat_cnt    <= w_lat_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_owner      <= w_owner_nxt;
      r_we         <= w_we_nxt;
      r_mem_addr   <= w_addr_nxt;
      r_mem_wdata  <= w_wdata_nxt;
      r_m0_gnt     <= w_issue_nxt & ~w_owner_nxt;
      r_m1_gnt     <= w_issue_nxt & w_owner_nxt;
      r_m0_rvalid  <= w_rvalid_nxt & ~w_owner_nxt;
      r_m1_rvalid  <= w_rvalid_nxt & w_owner_nxt;
      r_mem_write  <= w_issue_nxt & w_we_nxt;
      r_mem_read   <= w_issue_nxt & ~w_we_nxt;
    end
  end

  assign m0_gnt    = r_m0_gnt;
  assign m1_gnt    = r_m1_gnt;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_write = r_mem_write;
  assign mem_read  = r_mem_read;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LATENCY 0 and 2) driven by directed and random
// requesters, checked every cycle against a transaction-schedule reference model.
module tb_dmem_arbiter;

  localparam int NI     = 2;
  localparam int SLIM   = 4;
  localparam int M_RAND = 0;
  localparam int M_CONT = 1;
  localparam int M_IDLE = 2;
  localparam int M_M0RD = 3;
  localparam int M_M1WR = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_init;
  logic        req   [NI][2];
  logic        we    [NI][2];
  logic [63:0] addr  [NI][2];
  logic [63:0] wdata [NI][2];
  logic        gnt   [NI][2];
  logic        rvalid[NI][2];
  logic [63:0] rdata [NI][2];
  logic [63:0] mem_addr [NI];
  logic [63:0] mem_wdata[NI];
  logic [63:0] mem_rdata[NI];
  logic        mem_write[NI];
  logic        mem_read [NI];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit in_rst  = 1'b1;

  // reference model state
  int          idle_cyc[NI];
  int          iss_cyc [NI];
  int          rv_cyc  [NI];
  bit          own     [NI];
  bit          m_we    [NI];
  logic [63:0] m_addr  [NI];
  logic [63:0] m_wdata [NI];
  int          starve  [NI];
  bit          gprev   [NI][2];
  logic [63:0] rmem    [NI][64];

  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'(i) * 32'h0101_0101};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [63:0] dmem [64];

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LATENCY(g == 0 ? 0 : 2), .STARVE_LIMIT(SLIM)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(req[g][0]), .m0_we(we[g][0]), .m0_addr(addr[g][0]), .m0_wdata(wdata[g][0]),
      .m0_gnt(gnt[g][0]), .m0_rvalid(rvalid[g][0]), .m0_rdata(rdata[g][0]),
      .m1_req(req[g][1]), .m1_we(we[g][1]), .m1_addr(addr[g][1]), .m1_wdata(wdata[g][1]),
      .m1_gnt(gnt[g][1]), .m1_rvalid(rvalid[g][1]), .m1_rdata(rdata[g][1]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_write(mem_write[g]),
      .mem_read(mem_read[g]), .mem_rdata(mem_rdata[g])
    );

    // Data_Memory stand-in; address is held after issue, so a combinational read serves any latency
    assign mem_rdata[g] = dmem[mem_addr[g][5:0]];
    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 64; i++) dmem[i] <= init_val(i);
      end else if (mem_write[g]) begin
        dmem[mem_addr[g][5:0]] <= mem_wdata[g];
      end
    end
  end

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
  endtask

  task automatic zero_chk();
    for (int k = 0; k < NI; k++) begin
      chk("rst_gnt0", k, 64'(gnt[k][0]), 64'd0);
      chk("rst_gnt1", k, 64'(gnt[k][1]), 64'd0);
      chk("rst_rv0", k, 64'(rvalid[k][0]), 64'd0);
      chk("rst_rv1", k, 64'(rvalid[k][1]), 64'd0);
      chk("rst_mw", k, 64'(mem_write[k]), 64'd0);
      chk("rst_mr", k, 64'(mem_read[k]), 64'd0);
      chk("rst_addr", k, mem_addr[k], 64'd0);
      chk("rst_wdata", k, mem_wdata[k], 64'd0);
    end
  endtask

  task automatic tick(input bit rst_lvl, input int mode);
    bit          eg [NI][2];
    bit          erv[NI][2];
    bit          ew [NI];
    bit          er [NI];
    logic [63:0] ea [NI];
    logic [63:0] ed [NI];
    logic [63:0] erd[NI];
    bit          st;
    bit          win;
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (gprev[k][p]) req[k][p] = 1'b0;
        case (mode)
          M_RAND:  st = ($urandom_range(0, 2) == 0);
          M_CONT:  st = 1'b1;
          M_M0RD:  st = (p == 0);
          M_M1WR:  st = (p == 1);
          default: st = 1'b0;
        endcase
        if (!req[k][p] && st) begin
          req[k][p]   = 1'b1;
          we[k][p]    = (mode == M_CONT || mode == M_M1WR) ? 1'b1 :
                        (mode == M_M0RD) ? 1'b0 : 1'($urandom_range(0, 1));
          addr[k][p]  = (mode == M_M0RD) ? 64'h8 : 64'($urandom_range(0, 63));
          wdata[k][p] = {$urandom, $urandom};
        end
      end
    end
    if (!rst_lvl) begin
      reset  = 1'b0;
      in_rst = 1'b1;
      #1;
      zero_chk();
      for (int k = 0; k < NI; k++) begin
        starve[k] = 0; iss_cyc[k] = -1; rv_cyc[k] = -1;
        m_addr[k] = 64'd0; m_wdata[k] = 64'd0;
        gprev[k][0] = 1'b0; gprev[k][1] = 1'b0;
      end
    end else begin
      reset = 1'b1;
      if (in_rst) begin
        in_rst = 1'b0;
        for (int k = 0; k < NI; k++) idle_cyc[k] = cyc;
      end
      for (int k = 0; k < NI; k++) begin
        for (int p = 0; p < 2; p++) begin
          eg[k][p]  = (iss_cyc[k] == cyc) && (int'(own[k]) == p);
          erv[k][p] = (rv_cyc[k] == cyc) && (int'(own[k]) == p);
        end
        ew[k]  = (iss_cyc[k] == cyc) && m_we[k];
        er[k]  = (iss_cyc[k] == cyc) && !m_we[k];
        ea[k]  = m_addr[k];
        ed[k]  = m_wdata[k];
        erd[k] = rmem[k][m_addr[k][5:0]];
        if (ew[k]) rmem[k][m_addr[k][5:0]] = m_wdata[k];
        if (cyc == idle_cyc[k]) begin
          if (req[k][0] || req[k][1]) begin
            win        = req[k][1] && (!req[k][0] || starve[k] >= SLIM);
            own[k]     = win;
            m_we[k]    = we[k][win];
            m_addr[k]  = addr[k][win];
            m_wdata[k] = wdata[k][win];
            iss_cyc[k] = cyc + 1;
            rv_cyc[k]  = m_we[k] ? -1 : cyc + 1 + lat_of(k);
            idle_cyc[k] = m_we[k] ? cyc + 2 : cyc + 2 + lat_of(k);
          end else begin
            idle_cyc[k] = cyc + 1;
          end
        end
      end
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk("gnt0", k, 64'(gnt[k][0]), 64'(eg[k][0]));
        chk("gnt1", k, 64'(gnt[k][1]), 64'(eg[k][1]));
        chk("rvalid0", k, 64'(rvalid[k][0]), 64'(erv[k][0]));
        chk("rvalid1", k, 64'(rvalid[k][1]), 64'(erv[k][1]));
        chk("mem_write", k, 64'(mem_write[k]), 64'(ew[k]));
        chk("mem_read", k, 64'(mem_read[k]), 64'(er[k]));
        chk("mem_addr", k, mem_addr[k], ea[k]);
        chk("mem_wdata", k, mem_wdata[k], ed[k]);
        if (erv[k][0]) chk("rdata0", k, rdata[k][0], erd[k]);
        if (erv[k][1]) chk("rdata1", k, rdata[k][1], erd[k]);
        if (eg[k][1]) starve[k] = 0;
        else if (req[k][1] && starve[k] < SLIM) starve[k]++;
        gprev[k][0] = eg[k][0];
        gprev[k][1] = eg[k][1];
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    mem_init = 1'b1;
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0; we[k][p] = 1'b0; addr[k][p] = 64'd0; wdata[k][p] = 64'd0;
        gprev[k][p] = 1'b0;
      end
      for (int i = 0; i < 64; i++) rmem[k][i] = init_val(i);
      starve[k] = 0; iss_cyc[k] = -1; rv_cyc[k] = -1; idle_cyc[k] = 0;
      own[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = 64'd0; m_wdata[k] = 64'd0;
    end
    #1 reset = 1'b0;
    #1 zero_chk();
    tick(1'b0, M_IDLE);
    mem_init = 1'b0;
    tick(1'b0, M_IDLE);

    // both ports writing back to back: port 1 breaks through after four waits
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, M_CONT);
      chk("t3_gnt0", 0, 64'(gnt[0][0]), 64'(i == 1 || i == 3 || i == 7));
      chk("t3_gnt1", 0, 64'(gnt[0][1]), 64'(i == 5));
    end
    repeat (12) tick(1'b1, M_IDLE);

    // latency-0 read completes in the grant cycle; latency-2 read is then cut by reset
    tick(1'b1, M_M0RD);
    tick(1'b1, M_IDLE);
    chk("t5_gnt0", 0, 64'(gnt[0][0]), 64'd1);
    chk("t5_mem_read", 0, 64'(mem_read[0]), 64'd1);
    chk("t5_rvalid0", 0, 64'(rvalid[0][0]), 64'd1);
    chk("t5_rdata0", 0, rdata[0][0], init_val(8));
    chk("t4_gnt0", 1, 64'(gnt[1][0]), 64'd1);
    chk("t4_rvalid0", 1, 64'(rvalid[1][0]), 64'd0);
    tick(1'b0, M_IDLE);
    tick(1'b1, M_IDLE);
    chk("t4_no_rv", 1, 64'(rvalid[1][0]), 64'd0);
    tick(1'b1, M_IDLE);
    chk("t4_no_rv", 1, 64'(rvalid[1][0]), 64'd0);
    tick(1'b1, M_M0RD);
    tick(1'b1, M_IDLE);
    chk("t4_regnt", 1, 64'(gnt[1][0]), 64'd1);
    repeat (6) tick(1'b1, M_IDLE);

    // lone port-1 request is granted on the next cycle
    tick(1'b1, M_M1WR);
    tick(1'b1, M_IDLE);
    for (int k = 0; k < NI; k++) chk("t6_gnt1", k, 64'(gnt[k][1]), 64'd1);
    repeat (4) tick(1'b1, M_IDLE);

    for (int n = 0; n < 3000; n++) begin
      tick(($urandom_range(0, 249) != 0), M_RAND);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
